// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and default sizing for the digital lock
package lock_pkg;
  localparam int DEF_DIGITS = 4;
  localparam int CW = 4 * DEF_DIGITS;
  localparam logic [CW-1:0] DEF_CODE = 16'h1234;
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, PROG, LOCKOUT} state_e;
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lock_code_buffer.sv
// lock_code_buffer: digit shift register with saturating digit count and clear
module lock_code_buffer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic [3:0]            digit_i,
  output logic [4*DIGITS-1:0]   code_o,
  output logic                  full_o
);
  localparam int NW = $clog2(DIGITS + 1);
  logic [4*DIGITS-1:0] code_q, code_d;
  logic [NW-1:0]       cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else begin
      code_q <= code_d;
      cnt_q  <= cnt_d;
    end
  // digits beyond DIGITS are dropped so the buffer keeps the first code typed
  always_comb begin
    full_o = cnt_q == NW'(DIGITS);
    code_d = clr_i ? '0 : (shift_i && !full_o) ? {code_q[4*DIGITS-5:0], digit_i} : code_q;
    cnt_d  = clr_i ? '0 : (shift_i && !full_o) ? cnt_q + NW'(1) : cnt_q;
  end
  assign code_o = code_q;
endmodule

// File: rtl/lock_controller.sv
// lock_controller: keypad sequencing, unlock timing, failure lockout and code programming
module lock_controller
  import lock_pkg::*;
#(
  parameter int                  DIGITS         = DEF_DIGITS,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = DEF_CODE,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  UNLOCK_CYCLES  = 1000,
  parameter int                  LOCKOUT_CYCLES = 5000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_digit,
  input  logic                key_enter,
  input  logic                key_clear,
  input  logic                prog_req,
  input  logic                match,
  output logic [4*DIGITS-1:0] entered_code,
  output logic [4*DIGITS-1:0] stored_code,
  output logic                unlocked,
  output logic                err_pulse,
  output logic                lockout,
  output logic                prog_active
);
  localparam int TW = $clog2(max2(max2(UNLOCK_CYCLES, LOCKOUT_CYCLES), 2));
  localparam int FW = $clog2(MAX_FAILS + 1);
  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [4*DIGITS-1:0] stored_q, stored_d;
  logic                err_q, err_d;
  logic                clr, shift, full;
  lock_code_buffer #(.DIGITS(DIGITS)) u_buf (
    .clk(clk), .rst(rst), .clr_i(clr), .shift_i(shift), .digit_i(key_digit),
    .code_o(entered_code), .full_o(full)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      fail_q   <= '0;
      stored_q <= DEFAULT_CODE;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      stored_q <= stored_d;
      err_q    <= err_d;
    end
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    fail_d   = fail_q;
    stored_d = stored_q;
    err_d    = 1'b0;
    clr      = 1'b0;
    shift    = 1'b0;
    unique case (state_q)
      IDLE, ENTRY: begin
        if (key_clear) clr = 1'b1;
        else if (key_enter) state_d = CHECK;
        else if (key_valid) begin
          shift   = 1'b1;
          state_d = ENTRY;
        end
      end
      CHECK: begin
        clr = 1'b1;
        if (match && full) begin
          state_d = UNLOCKED;
          fail_d  = '0;
          timer_d = TW'(UNLOCK_CYCLES - 1);
        end else begin
          err_d   = 1'b1;
          fail_d  = fail_q + FW'(1);
          state_d = (fail_d == FW'(MAX_FAILS)) ? LOCKOUT : IDLE;
          timer_d = (fail_d == FW'(MAX_FAILS)) ? TW'(LOCKOUT_CYCLES - 1) : timer_q;
        end
      end
      UNLOCKED: begin
        if (prog_req) state_d = PROG;
        else if (timer_q == '0) state_d = IDLE;
        else timer_d = timer_q - TW'(1);
      end
      // a short code is rejected but the user stays in programming mode
      PROG: begin
        if (key_clear) clr = 1'b1;
        else if (key_enter) begin
          clr = 1'b1;
          if (full) begin
            stored_d = entered_code;
            state_d  = IDLE;
          end else err_d = 1'b1;
        end else if (key_valid) shift = 1'b1;
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = IDLE;
          fail_d  = '0;
        end else timer_d = timer_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  assign stored_code = stored_q;
  assign unlocked    = state_q == UNLOCKED || state_q == PROG;
  assign prog_active = state_q == PROG;
  assign lockout     = state_q == LOCKOUT;
  assign err_pulse   = err_q;
endmodule

// File: tb/tb_lock_controller.sv
// tb_lock_controller: directed scenario tests for the lock sequencing FSM
module tb_lock_controller;
  logic clk = 0, rst = 1;
  logic key_valid = 0, key_enter = 0, key_clear = 0, prog_req = 0;
  logic [3:0] key_digit = 0;
  logic [15:0] entered_code, stored_code;
  logic unlocked, err_pulse, lockout, prog_active, match;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign match = entered_code == stored_code;

  lock_controller dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .key_enter(key_enter), .key_clear(key_clear), .prog_req(prog_req), .match(match),
    .entered_code(entered_code), .stored_code(stored_code), .unlocked(unlocked),
    .err_pulse(err_pulse), .lockout(lockout), .prog_active(prog_active)
  );

  task automatic press(input logic v, input logic [3:0] d, input logic e, input logic c, input logic p);
    @(negedge clk);
    key_valid = v; key_digit = d; key_enter = e; key_clear = c; prog_req = p;
    @(negedge clk);
    key_valid = 0; key_enter = 0; key_clear = 0; prog_req = 0;
  endtask

  task automatic digit(input logic [3:0] d);
    press(1, d, 0, 0, 0);
  endtask

  task automatic enter();
    press(0, 0, 1, 0, 0);
  endtask

  task automatic code4(input logic [15:0] c);
    for (int i = 0; i < 4; i++) digit(c[15-4*i -: 4]);
  endtask

  task automatic wait_relock();
    int n = 0;
    while (unlocked === 1'b1 && n < 1100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (unlocked !== 1'b0) begin errors++; $display("FAIL relock_timeout unlocked=%b want 0", unlocked); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 6;
    if (unlocked !== 0) begin errors++; $display("FAIL reset_unlocked got=%b want 0", unlocked); end
    if (err_pulse !== 0) begin errors++; $display("FAIL reset_err got=%b want 0", err_pulse); end
    if (lockout !== 0) begin errors++; $display("FAIL reset_lockout got=%b want 0", lockout); end
    if (prog_active !== 0) begin errors++; $display("FAIL reset_prog got=%b want 0", prog_active); end
    if (entered_code !== 16'h0) begin errors++; $display("FAIL reset_entered got=%h want 0000", entered_code); end
    if (stored_code !== 16'h1234) begin errors++; $display("FAIL reset_stored got=%h want 1234", stored_code); end
    rst = 0;
  endtask

  task automatic test_unlock();
    int n = 0;
    code4(16'h1234);
    checks++;
    if (entered_code !== 16'h1234) begin errors++; $display("FAIL unlock_buf got=%h want 1234", entered_code); end
    enter();
    checks++;
    if (unlocked !== 0) begin errors++; $display("FAIL unlock_early got=%b want 0", unlocked); end
    @(negedge clk);
    checks++;
    if (unlocked !== 1) begin errors++; $display("FAIL unlock_n2 got=%b want 1", unlocked); end
    while (unlocked === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 1000) begin errors++; $display("FAIL unlock_hold got=%0d want 1000", n); end
  endtask

  task automatic test_lockout();
    int n;
    for (int k = 0; k < 3; k++) begin
      code4(16'h2458);
      enter();
      checks++;
      if (err_pulse !== 0) begin errors++; $display("FAIL fail_err_early got=%b want 0", err_pulse); end
      @(negedge clk);
      checks += 3;
      if (err_pulse !== 1) begin errors++; $display("FAIL fail_err got=%b want 1", err_pulse); end
      if (unlocked !== 0) begin errors++; $display("FAIL fail_unlocked got=%b want 0", unlocked); end
      if (lockout !== (k == 2)) begin errors++; $display("FAIL fail_lockout%0d got=%b want %b", k, lockout, k == 2); end
      @(negedge clk);
      checks++;
      if (err_pulse !== 0) begin errors++; $display("FAIL fail_err_len got=%b want 0", err_pulse); end
    end
    code4(16'h1234);
    enter();
    checks += 2;
    if (entered_code !== 16'h0) begin errors++; $display("FAIL lockout_keys got=%h want 0000", entered_code); end
    if (lockout !== 1) begin errors++; $display("FAIL lockout_held got=%b want 1", lockout); end
    n = 11;
    while (lockout === 1'b1 && n < 6000) begin
      n++;
      @(negedge clk);
    end
    checks += 2;
    if (n != 5000) begin errors++; $display("FAIL lockout_len got=%0d want 5000", n); end
    if (unlocked !== 0) begin errors++; $display("FAIL lockout_exit_unlocked got=%b want 0", unlocked); end
    for (int k = 0; k < 3; k++) begin
      code4(16'h2458);
      enter();
      @(negedge clk);
      checks++;
      if (lockout !== (k == 2)) begin errors++; $display("FAIL refail_lockout%0d got=%b want %b", k, lockout, k == 2); end
    end
    @(negedge clk);
    rst = 1;
    #1;
    checks += 3;
    if (lockout !== 0) begin errors++; $display("FAIL rst_lockout got=%b want 0", lockout); end
    if (err_pulse !== 0) begin errors++; $display("FAIL rst_lockout_err got=%b want 0", err_pulse); end
    if (stored_code !== 16'h1234) begin errors++; $display("FAIL rst_lockout_stored got=%h want 1234", stored_code); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_short();
    digit(1); digit(2); digit(3);
    enter();
    @(negedge clk);
    checks += 2;
    if (err_pulse !== 1) begin errors++; $display("FAIL short_err got=%b want 1", err_pulse); end
    if (unlocked !== 0) begin errors++; $display("FAIL short_unlocked got=%b want 0", unlocked); end
    code4(16'h1234);
    digit(5);
    checks++;
    if (entered_code !== 16'h1234) begin errors++; $display("FAIL drop5_buf got=%h want 1234", entered_code); end
    enter();
    @(negedge clk);
    checks++;
    if (unlocked !== 1) begin errors++; $display("FAIL drop5_unlock got=%b want 1", unlocked); end
    wait_relock();
  endtask

  task automatic test_back_to_back();
    digit(1); digit(2); digit(3);
    press(1, 4, 1, 0, 0);
    @(negedge clk);
    checks += 2;
    if (err_pulse !== 1) begin errors++; $display("FAIL b2b_err got=%b want 1", err_pulse); end
    if (unlocked !== 0) begin errors++; $display("FAIL b2b_unlocked got=%b want 0", unlocked); end
    digit(9); digit(9);
    press(0, 0, 0, 1, 0);
    checks++;
    if (entered_code !== 16'h0) begin errors++; $display("FAIL clear_buf got=%h want 0000", entered_code); end
    code4(16'h1234);
    enter();
    @(negedge clk);
    checks++;
    if (unlocked !== 1) begin errors++; $display("FAIL clear_unlock got=%b want 1", unlocked); end
    wait_relock();
  endtask

  task automatic test_prog();
    code4(16'h1234);
    enter();
    @(negedge clk);
    press(0, 0, 0, 0, 1);
    checks += 2;
    if (prog_active !== 1) begin errors++; $display("FAIL prog_enter got=%b want 1", prog_active); end
    if (unlocked !== 1) begin errors++; $display("FAIL prog_unlocked got=%b want 1", unlocked); end
    digit(0);
    enter();
    checks += 2;
    if (err_pulse !== 1) begin errors++; $display("FAIL prog_short_err got=%b want 1", err_pulse); end
    if (prog_active !== 1) begin errors++; $display("FAIL prog_short_stay got=%b want 1", prog_active); end
    code4(16'h0007);
    enter();
    checks += 3;
    if (stored_code !== 16'h0007) begin errors++; $display("FAIL prog_stored got=%h want 0007", stored_code); end
    if (unlocked !== 0) begin errors++; $display("FAIL prog_lock got=%b want 0", unlocked); end
    if (prog_active !== 0) begin errors++; $display("FAIL prog_exit got=%b want 0", prog_active); end
    code4(16'h1234);
    enter();
    @(negedge clk);
    checks += 2;
    if (err_pulse !== 1) begin errors++; $display("FAIL old_code_err got=%b want 1", err_pulse); end
    if (unlocked !== 0) begin errors++; $display("FAIL old_code_unlocked got=%b want 0", unlocked); end
    code4(16'h0007);
    enter();
    @(negedge clk);
    checks++;
    if (unlocked !== 1) begin errors++; $display("FAIL new_code_unlock got=%b want 1", unlocked); end
    press(0, 0, 0, 0, 1);
    digit(3);
    rst = 1;
    #1;
    checks += 5;
    if (unlocked !== 0) begin errors++; $display("FAIL rst_prog_unlocked got=%b want 0", unlocked); end
    if (prog_active !== 0) begin errors++; $display("FAIL rst_prog_active got=%b want 0", prog_active); end
    if (lockout !== 0) begin errors++; $display("FAIL rst_prog_lockout got=%b want 0", lockout); end
    if (entered_code !== 16'h0) begin errors++; $display("FAIL rst_prog_entered got=%h want 0000", entered_code); end
    if (stored_code !== 16'h1234) begin errors++; $display("FAIL rst_prog_stored got=%h want 1234", stored_code); end
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lockout();
    test_short();
    test_back_to_back();
    test_prog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
